// File: rtl/instruction_fetch_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH_BOOT  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_DROP  = 3'd3,
        FETCH_FAULT = 3'd4
    } fetch_state_t;

    function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_slot.sv
// One-entry output register for decode; flush beats load, load beats consume.
module fetch_slot
    import instruction_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            consume,
    input  logic [31:0]     load_inst,
    input  logic [XLEN-1:0] load_pc,
    input  logic            load_fault,
    output logic            valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic            fault
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
            fault <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            fault <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
            fault <= load_fault;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, redirect-aware drop of stale data,
// misaligned-PC fault tagging and a one-entry registered slot toward decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_advance_o,
    input  logic            redirect_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_fault_o
);

    fetch_state_t    state, next_state;
    logic [XLEN-1:0] req_pc;
    logic            slot_free;
    logic            req_fire;
    logic            slot_load;
    logic [31:0]     slot_inst;
    logic [XLEN-1:0] slot_pc;
    logic            slot_fault;

    assign slot_free       = !inst_valid_o || inst_ready_i;
    assign imem_req_addr_o = pc_i;
    assign req_fire        = imem_req_valid_o && imem_req_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc <= '0;
        end else if (req_fire) begin
            req_pc <= pc_i;
        end
    end

    // Requests only go out when the slot can take the answer, so a response never overflows it.
    always_comb begin
        next_state       = state;
        imem_req_valid_o = 1'b0;
        pc_advance_o     = 1'b0;
        slot_load        = 1'b0;
        slot_inst        = imem_rsp_data_i;
        slot_pc          = req_pc;
        slot_fault       = 1'b0;
        case (state)
            FETCH_BOOT: next_state = FETCH_REQ;
            FETCH_REQ: begin
                if (pc_aligned(pc_i)) begin
                    imem_req_valid_o = slot_free && !redirect_i;
                    if (slot_free && !redirect_i && imem_req_ready_i) begin
                        next_state = FETCH_WAIT;
                    end
                end else if (slot_free && !redirect_i) begin
                    slot_load  = 1'b1;
                    slot_inst  = NOP_INST;
                    slot_pc    = pc_i;
                    slot_fault = 1'b1;
                    next_state = FETCH_FAULT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid_i) begin
                    next_state = FETCH_REQ;
                    if (!redirect_i) begin
                        slot_load    = 1'b1;
                        pc_advance_o = 1'b1;
                    end
                end else if (redirect_i) begin
                    next_state = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_rsp_valid_i) begin
                    next_state = FETCH_REQ;
                end
            end
            FETCH_FAULT: begin
                if (redirect_i) begin
                    next_state = FETCH_REQ;
                end
            end
            default: next_state = FETCH_BOOT;
        endcase
    end

    fetch_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_i),
        .load       (slot_load),
        .consume    (inst_valid_o && inst_ready_i),
        .load_inst  (slot_inst),
        .load_pc    (slot_pc),
        .load_fault (slot_fault),
        .valid      (inst_valid_o),
        .inst       (inst_o),
        .pc         (inst_pc_o),
        .fault      (inst_fault_o)
    );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly downstream of the program counter: takes the current PC, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word into a one-entry output slot for decode. It tells the PC register when to advance. It also discards in-flight fetches on a control-flow redirect. It inserts one idle cycle after reset release, so the word at the reset PC is fetched only after reset has been released, never while reset is still asserted.

## Interface
- XLEN, from Parameters.vh (32): address/PC width
- NOP_INST, 32'h00000013: word presented on reset, flush and fault
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- pc_i  in  XLEN  current PC from the PC register
- pc_advance_o  out  1  enable for PC register update, one-cycle pulse
- redirect_i  in  1  branch/jump is rewriting the PC this cycle
- imem_req_valid_o  out  1  read request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  read address, equals pc_i
- imem_rsp_valid_i  in  1  read data valid, one cycle
- imem_rsp_data_i  in  32  instruction word
- inst_valid_o  out  1  output slot holds an instruction
- inst_ready_i  in  1  decode consumes the slot
- inst_o  out  32  instruction
- inst_pc_o  out  XLEN  PC of inst_o
- inst_fault_o  out  1  misaligned-fetch fault tag

## Operation
- States: BOOT, REQ, WAIT, DROP, FAULT.
- BOOT: entered on reset. No request. Unconditionally goes to REQ on the next edge.
- slot_free = !inst_valid_o || inst_ready_i.
- REQ, aligned pc_i[1:0]==0:
  - imem_req_valid_o = slot_free && !redirect_i.
  - On handshake: latch pc_i into req_pc, then go to WAIT.
- REQ, misaligned pc_i, slot_free, no redirect:
  - No request.
  - Load slot with NOP_INST, inst_pc_o = pc_i, fault = 1.
  - Go to FAULT.
- FAULT: no requests. redirect_i → REQ.
- WAIT, imem_rsp_valid_i && !redirect_i:
  - Load slot with rsp data, inst_pc_o = req_pc, fault = 0.
  - pc_advance_o = 1 combinationally this cycle.
  - Go to REQ.
- WAIT, redirect_i without response → DROP.
- WAIT, redirect_i with response in the same cycle → discard the data, go to REQ, pc_advance_o = 0.
- DROP: waits for the orphan response. On imem_rsp_valid_i, discard it and go to REQ.
- The issue rule guarantees the slot is free when a response arrives, so no overflow path exists.
- Slot consume: inst_valid_o && inst_ready_i clears valid unless it is reloaded in the same cycle.
- redirect_i in any state:
  - Clears inst_valid_o at the next edge, overriding a same-cycle load.
  - Forces pc_advance_o = 0; the redirect owns the PC.
- imem_rsp_valid_i in BOOT, REQ or FAULT is ignored.
- Request-channel rule:
  - Once valid, the address is held until ready.
  - Exception: redirect_i withdraws the request in the same cycle.
  - imem_req_valid_o is combinational from state, slot_free and redirect_i.

## Timing
- Reset values:
  - state = BOOT
  - inst_valid_o = 0, inst_o = NOP_INST, inst_pc_o = 0, inst_fault_o = 0
  - pc_advance_o = 0, imem_req_valid_o = 0
  - req_pc = 0
- Reset mid-operation: any outstanding response after reset release is not tracked. The memory side is reset by the same rst.
- First request is at the 2nd rising edge after reset deassertion: the BOOT cycle, then REQ.
- Request handshake at cycle N gives the earliest response at N+1.
- Response at cycle M:
  - inst_valid_o is high from M+1.
  - The PC updates at the edge ending cycle M.
  - The next request can go out at M+1 if inst_ready_i is high.
- Zero-wait memory with ready decode gives 1 instruction per 2 cycles.
- The output slot is registered. pc_advance_o and imem_req_* are combinational.

## Structure
- XLEN and NOP_INST encoding live in Parameters.vh. Add the state encodings there as localparams: FETCH_BOOT, FETCH_REQ, FETCH_WAIT, FETCH_DROP, FETCH_FAULT.
- Sub-module: fetch_slot, a one-entry register holding {valid, inst, pc, fault} with load/consume/flush priority flush > load > consume.
- The FSM stays in instruction_fetch.

## Test plan
- Reset release, pc_i=0, memory always ready, returns 32'h00500093 one cycle later:
  - No request during the BOOT cycle.
  - Request addr 0 on the next cycle.
  - inst_valid_o=1, inst_o=32'h00500093, inst_pc_o=0.
  - One pc_advance_o pulse.
- Decode stalls (inst_ready_i=0) with the slot full → imem_req_valid_o stays 0. Raise inst_ready_i → request issues in that same cycle.
- Redirect in WAIT, response arrives 3 cycles later with 32'hDEADBEEF:
  - The word is never presented.
  - No pc_advance_o pulse.
  - The next request uses the new pc_i=32'h100.
- Redirect in the same cycle as the response → data discarded, slot invalid next cycle, state REQ.
- pc_i=32'h102:
  - No request.
  - inst_valid_o=1, inst_fault_o=1, inst_o=NOP_INST, inst_pc_o=32'h102.
  - Requests stay blocked until redirect_i.
- Assert rst while in WAIT → all outputs return to their reset values immediately (asynchronous), and the BOOT cycle repeats after release.
